// File: rtl/etc_pkg.sv
// Shared types and constants for the ETC tile sequencer and its tile buffers.
// Tile and row typedefs are sized by the package default element width.
package etc_pkg;

    localparam int TILE_N = 4;
    localparam int W_DEF  = 16;
    localparam int IDX_W  = 2;

    localparam logic [1:0] OP_GEMM = 2'd0;
    localparam logic [1:0] OP_APSP = 2'd1;

    typedef enum logic [1:0] {
        ST_LOAD_A = 2'd0,
        ST_LOAD_B = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DRAIN  = 2'd3
    } etc_seq_state_t;

    typedef logic [TILE_N-1:0][W_DEF-1:0] etc_row_t;
    typedef logic [TILE_N-1:0][TILE_N-1:0][W_DEF-1:0] etc_tile_t;

endpackage

// File: rtl/etc_tile_buf.sv
// Four-row tile register file: row-indexed write, optional whole-tile load,
// asynchronous clear and full-tile parallel read.
module etc_tile_buf
    import etc_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 we_i,
    input  logic [IDX_W-1:0]                     widx_i,
    input  logic [TILE_N-1:0][W-1:0]             wrow_i,
    input  logic                                 load_i,
    input  logic [TILE_N-1:0][TILE_N-1:0][W-1:0] tile_i,
    output logic [TILE_N-1:0][TILE_N-1:0][W-1:0] tile_o
);

    logic [TILE_N-1:0][TILE_N-1:0][W-1:0] mem_q;
    logic [TILE_N-1:0][TILE_N-1:0][W-1:0] mem_d;

    // A whole-tile load wins over a row write; the two are never used together.
    always_comb begin
        mem_d = mem_q;
        if (load_i) begin
            mem_d = tile_i;
        end else if (we_i) begin
            mem_d[widx_i] = wrow_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign tile_o = mem_q;

endmodule

// File: rtl/etc_tile_sequencer.sv
// Row-serial loader/drainer for the 4x4 tensor core tile engine.
// Define ETC_SEQ_PERF_EN to add the tile_count / stall_count performance counters.
module etc_tile_sequencer
    import etc_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int LAT = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [TILE_N-1:0][W-1:0]             in_row,
    input  logic [1:0]                           in_op,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [TILE_N-1:0][W-1:0]             out_row,
    output logic                                 out_last,
    output logic [1:0]                           core_op,
    output logic [TILE_N-1:0][TILE_N-1:0][W-1:0] core_inA,
    output logic [TILE_N-1:0][TILE_N-1:0][W-1:0] core_inB,
    input  logic [TILE_N-1:0][TILE_N-1:0][W-1:0] core_out,
`ifdef ETC_SEQ_PERF_EN
    output logic [31:0]                          tile_count,
    output logic [31:0]                          stall_count,
`endif
    output logic                                 busy
);

    // Handshakes: a row moves on a cycle where valid & ready are both high;
    // valid never waits on ready, and a held valid keeps its data stable.
    localparam int CNT_W = (LAT > 0) ? $clog2(LAT + 1) : 1;

    etc_seq_state_t   state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;

    logic in_fire, out_fire, cnt_done;
    logic a_we, b_we, res_load;
    logic [TILE_N-1:0][TILE_N-1:0][W-1:0] res_tile;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign cnt_done = (cnt_q == CNT_W'(LAT));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_we      = 1'b0;
        b_we      = 1'b0;
        res_load  = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state_q)
            ST_LOAD_A: begin
                in_ready = 1'b1;
                if (in_fire) begin
                    a_we  = 1'b1;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == '0) begin
                        op_d = in_op;
                    end
                    if (idx_q == IDX_W'(TILE_N - 1)) begin
                        state_d = ST_LOAD_B;
                    end
                end
            end
            ST_LOAD_B: begin
                in_ready = 1'b1;
                if (in_fire) begin
                    b_we  = 1'b1;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(TILE_N - 1)) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            ST_WAIT: begin
                // Operands have been stable since the first WAIT cycle; core_out is
                // valid once LAT cycles have elapsed.
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_done) begin
                    res_load = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                out_last  = (idx_q == IDX_W'(TILE_N - 1));
                if (out_fire) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(TILE_N - 1)) begin
                        state_d = ST_LOAD_A;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD_A;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD_A;
            idx_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    etc_tile_buf #(.W(W)) u_a_buf (
        .clk    (clk),
        .rst    (rst),
        .we_i   (a_we),
        .widx_i (idx_q),
        .wrow_i (in_row),
        .load_i (1'b0),
        .tile_i ('0),
        .tile_o (core_inA)
    );

    etc_tile_buf #(.W(W)) u_b_buf (
        .clk    (clk),
        .rst    (rst),
        .we_i   (b_we),
        .widx_i (idx_q),
        .wrow_i (in_row),
        .load_i (1'b0),
        .tile_i ('0),
        .tile_o (core_inB)
    );

    etc_tile_buf #(.W(W)) u_res_buf (
        .clk    (clk),
        .rst    (rst),
        .we_i   (1'b0),
        .widx_i (idx_q),
        .wrow_i ('0),
        .load_i (res_load),
        .tile_i (core_out),
        .tile_o (res_tile)
    );

    assign core_op = op_q;
    assign out_row = res_tile[idx_q];
    assign busy    = !((state_q == ST_LOAD_A) && (idx_q == '0));

`ifdef ETC_SEQ_PERF_EN
    logic [31:0] tile_cnt_q, tile_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        tile_cnt_d  = tile_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (out_fire && out_last) begin
            tile_cnt_d = tile_cnt_q + 32'd1;
        end
        if (out_valid && !out_ready) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            tile_cnt_q  <= tile_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign tile_count  = tile_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_etc_tile_sequencer.sv
// Bench for etc_tile_sequencer with a behavioural LAT=2 core model and a row scoreboard.
// Covers GEMM, APSP, back-pressure, mid-load reset and op sampling; optional perf counters.
module tb_etc_tile_sequencer;
  import etc_pkg::*;

  localparam int W   = 16;
  localparam int LAT = 2;

  typedef logic [3:0][W-1:0]      row_t;
  typedef logic [3:0][3:0][W-1:0] tile_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, out_valid, out_ready, out_last, busy;
  row_t       in_row, out_row;
  logic [1:0] in_op, core_op;
  tile_t      core_inA, core_inB, core_out;
`ifdef ETC_SEQ_PERF_EN
  logic [31:0] tile_count, stall_count;
`endif

  etc_tile_sequencer #(.W(W), .LAT(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_row      (in_row),
    .in_op       (in_op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_last    (out_last),
    .core_op     (core_op),
    .core_inA    (core_inA),
    .core_inB    (core_inB),
    .core_out    (core_out),
`ifdef ETC_SEQ_PERF_EN
    .tile_count  (tile_count),
    .stall_count (stall_count),
`endif
    .busy        (busy)
  );

  // behavioural core: GEMM = sum_k A[i][k]*B[k][j]; APSP = min(A[i][j], min_k A[i][k]+B[k][j])
  function automatic tile_t core_fn(tile_t a, tile_t b, logic [1:0] op);
    tile_t r;
    logic [W-1:0] acc, s;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (op == OP_GEMM) begin
          acc = '0;
          for (int k = 0; k < 4; k++) acc = acc + W'(a[i][k] * b[k][j]);
        end else begin
          acc = a[i][j];
          for (int k = 0; k < 4; k++) begin
            s = a[i][k] + b[k][j];
            if (s < acc) acc = s;
          end
        end
        r[i][j] = acc;
      end
    end
    return r;
  endfunction

  tile_t      m_a, m_b;
  logic [1:0] m_op;
  always @(posedge clk) begin
    m_a      <= core_inA;
    m_b      <= core_inB;
    m_op     <= core_op;
    core_out <= core_fn(m_a, m_b, m_op);
  end

  // scoreboard
  logic [4*W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_tiles = 0;
  int exp_stalls = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic send_row(input row_t r, input logic [1:0] op);
    int n;
    in_valid = 1'b1;
    in_row   = r;
    in_op    = op;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_load", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_op    = 2'($urandom_range(0, 3));
  endtask

  task automatic check_perf();
`ifdef ETC_SEQ_PERF_EN
    chk("tile_count", tile_count, exp_tiles);
    chk("stall_count", stall_count, exp_stalls);
`endif
  endtask

  task automatic run_tile(input tile_t a, input tile_t b, input logic [1:0] op0,
                          input logic [1:0] op_rest, input int stall_row, input int stall_n);
    tile_t exp_t, hold_a, hold_b;
    int lat, n;
    exp_t = core_fn(a, b, op0);
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_t[i]);
    for (int i = 0; i < 4; i++) begin
      send_row(a[i], (i == 0) ? op0 : op_rest);
      if (i == 0) chk("busy_load", busy, 1'b1);
    end
    for (int i = 0; i < 4; i++) send_row(b[i], op_rest);
    hold_a = core_inA;
    hold_b = core_inB;
    chk("core_inA_loaded", (hold_a == a), 1'b1);
    chk("core_inB_loaded", (hold_b == b), 1'b1);
    chk("core_op_loaded", core_op, op0);
    // in_valid held during WAIT/DRAIN must be ignored
    in_valid = 1'b1;
    in_row   = row_t'({$urandom, $urandom});
    lat = 1;
    while (!out_valid && lat < 20) begin
      chk("in_ready_wait", in_ready, 1'b0);
      chk("busy_wait", busy, 1'b1);
      @(negedge clk);
      lat++;
    end
    chk("first_valid_lat", lat, LAT + 2);
    for (int r = 0; r < 4; r++) begin
      out_ready = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("out_valid", out_valid, 1'b1);
      if (r == stall_row) begin
        for (int s = 0; s < stall_n; s++) begin
          chk("stall_row", out_row, exp_q[0]);
          chk("stall_valid", out_valid, 1'b1);
          chk("stall_last", out_last, (r == 3));
          @(negedge clk);
          exp_stalls++;
        end
      end
      chk("out_row", out_row, exp_q.pop_front());
      chk("out_last", out_last, (r == 3));
      chk("in_ready_drain", in_ready, 1'b0);
      chk("hold_inA", (core_inA == hold_a), 1'b1);
      chk("hold_inB", (core_inB == hold_b), 1'b1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    in_valid = 1'b0;
    exp_tiles++;
    chk("in_ready_after", in_ready, 1'b1);
    chk("busy_after", busy, 1'b0);
    chk("out_valid_after", out_valid, 1'b0);
    check_perf();
  endtask

  tile_t t_ident, t_ramp, t_five, t_one, t_ra, t_rb;

  initial begin
    in_valid  = 1'b0;
    in_row    = '0;
    in_op     = '0;
    out_ready = 1'b0;
    rst       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        t_ident[i][j] = (i == j) ? W'(1) : W'(0);
        t_ramp[i][j]  = W'(4 * i + j);
        t_five[i][j]  = W'(5);
        t_one[i][j]   = W'(1);
        t_ra[i][j]    = W'($urandom_range(0, 300));
        t_rb[i][j]    = W'($urandom_range(0, 300));
      end
    end
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_core_op", core_op, 2'd0);
    chk("rst_core_inA", (core_inA == '0), 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check_perf();

    // GEMM identity: result equals B ramp
    run_tile(t_ident, t_ramp, 2'd0, 2'd0, -1, 0);
    // APSP: all 5 vs all 1 -> 5 everywhere
    run_tile(t_five, t_one, 2'd1, 2'd1, -1, 0);
    // back-pressure on row 1 for 5 cycles
    run_tile(t_ident, t_ramp, 2'd0, 2'd0, 1, 5);

    // reset after 4 A rows and 3 B rows
    for (int i = 0; i < 4; i++) send_row(t_five[i], 2'd1);
    for (int i = 0; i < 3; i++) send_row(t_five[i], 2'd1);
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_out_valid", out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_tiles  = 0;
    exp_stalls = 0;
    @(negedge clk);
    check_perf();
    run_tile(t_ra, t_rb, 2'd0, 2'd0, $urandom_range(0, 3), $urandom_range(1, 4));

    // op sampled on A row 0 only: APSP despite op=0 on later rows
    run_tile(t_five, t_one, 2'd1, 2'd0, -1, 0);
    // random APSP with random stall
    run_tile(t_ra, t_rb, 2'd2, 2'd0, $urandom_range(0, 3), $urandom_range(1, 3));

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
